// File: rtl/bit_pkg.sv
// Shared definitions for the bitset / bit_reader pair: default word geometry
// and the bit_reader state encoding.
package bit_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int IDX_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    SCAN   = 2'd2
  } state_t;

endpackage

// File: rtl/bit_reader.sv
// Holds a word and answers single-bit or scan-to-MSB read requests over
// valid/ready handshakes on both the request and response sides.
module bit_reader
  import bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_mode,
  input  logic [IDX_W-1:0] req_index,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_bit,
  output logic [IDX_W-1:0] rsp_index,
  output logic             rsp_last,
  output logic             busy
);

  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_snap;
  logic [WIDTH-1:0] w_snap_next;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_next;
  logic             w_rsp_hs;
  logic             w_at_msb;

  assign w_rsp_hs = rsp_valid & rsp_ready;
  assign w_at_msb = (r_ptr == MSB_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_snap  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_snap  <= w_snap_next;
      r_ptr   <= w_ptr_next;
      if (load) begin
        r_word <= din;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_snap_next  = r_snap;
    w_ptr_next   = r_ptr;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          // A load in the accepting cycle wins over the stored word.
          w_snap_next  = load ? din : r_word;
          w_ptr_next   = req_index;
          w_state_next = req_mode ? SCAN : SINGLE;
        end
      end
      SINGLE: begin
        if (w_rsp_hs) begin
          w_state_next = IDLE;
        end
      end
      SCAN: begin
        if (w_rsp_hs) begin
          if (w_at_msb) begin
            w_state_next = IDLE;
          end else begin
            w_ptr_next = r_ptr + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // All response fields derive from registers only, so they hold under back-pressure.
  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign rsp_valid = busy;
  assign rsp_bit   = r_snap[r_ptr];
  assign rsp_index = r_ptr;
  assign rsp_last  = (r_state == SINGLE) || ((r_state == SCAN) && w_at_msb);

endmodule

// File: tb/tb_bit_reader.sv
// Directed bench for bit_reader: table of single reads plus hand-written
// scan, back-pressure, load-race and abort sequences.
module tb_bit_reader;

  localparam int WIDTH = 4;
  localparam int IDX_W = 2;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             req_valid;
  logic             req_ready;
  logic             req_mode;
  logic [IDX_W-1:0] req_index;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_bit;
  logic [IDX_W-1:0] rsp_index;
  logic             rsp_last;
  logic             busy;

  int total;
  int bad;

  bit_reader #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .din(din),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_index(req_index), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_bit(rsp_bit), .rsp_index(rsp_index), .rsp_last(rsp_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] word;
    logic [IDX_W-1:0] idx;
    logic             exp_bit;
  } single_vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_word(input logic [WIDTH-1:0] w);
    load = 1'b1;
    din  = w;
    step();
    load = 1'b0;
  endtask

  task automatic issue(input logic mode, input logic [IDX_W-1:0] idx);
    req_valid = 1'b1;
    req_mode  = mode;
    req_index = idx;
    step();
    req_valid = 1'b0;
  endtask

  task automatic single_read(input logic [IDX_W-1:0] idx, input logic exp_bit);
    rsp_ready = 1'b1;
    issue(1'b0, idx);
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_bit", 32'(rsp_bit), 32'(exp_bit));
    chk("single_index", 32'(rsp_index), 32'(idx));
    chk("single_last", 32'(rsp_last), 32'd1);
    step();
    chk("single_idle_ready", 32'(req_ready), 32'd1);
    chk("single_idle_valid", 32'(rsp_valid), 32'd0);
    $display("single idx=%0d bit=%0b", idx, rsp_bit);
  endtask

  single_vec_t vecs [5];
  logic [WIDTH-1:0] word;

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; load = 1'b0; din = '0; req_valid = 1'b0;
    req_mode = 1'b0; req_index = '0; rsp_ready = 1'b0;

    vecs[0] = '{4'b1100, 2'd2, 1'b1};
    vecs[1] = '{4'b1100, 2'd0, 1'b0};
    vecs[2] = '{4'b1010, 2'd3, 1'b1};
    vecs[3] = '{4'b1010, 2'd0, 1'b0};
    vecs[4] = '{4'b0110, 2'd1, 1'b1};

    step(); step();
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_bit", 32'(rsp_bit), 32'd0);
    chk("reset_rsp_index", 32'(rsp_index), 32'd0);
    chk("reset_rsp_last", 32'(rsp_last), 32'd0);
    rst_n = 1'b1;
    step();

    // Stray rsp_ready while idle must not start anything.
    rsp_ready = 1'b1;
    step(); step();
    chk("idle_rsp_ready_noop", 32'(rsp_valid), 32'd0);
    chk("idle_still_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      load_word(vecs[i].word);
      single_read(vecs[i].idx, vecs[i].exp_bit);
    end

    // Scan from 0 with continuous rsp_ready.
    word = 4'b0101;
    load_word(word);
    rsp_ready = 1'b1;
    issue(1'b1, 2'd0);
    for (int i = 0; i < WIDTH; i++) begin
      chk("scan_valid", 32'(rsp_valid), 32'd1);
      chk("scan_bit", 32'(rsp_bit), 32'(word[i]));
      chk("scan_index", 32'(rsp_index), 32'(i));
      chk("scan_last", 32'(rsp_last), (i == WIDTH - 1) ? 32'd1 : 32'd0);
      $display("scan idx=%0d bit=%0b last=%0b", rsp_index, rsp_bit, rsp_last);
      step();
    end
    chk("scan_done_ready", 32'(req_ready), 32'd1);

    // Scan starting at the MSB gives exactly one response.
    issue(1'b1, 2'd3);
    chk("scan_msb_index", 32'(rsp_index), 32'd3);
    chk("scan_msb_last", 32'(rsp_last), 32'd1);
    chk("scan_msb_bit", 32'(rsp_bit), 32'd0);
    step();
    chk("scan_msb_idle", 32'(busy), 32'd0);
    $display("scan msb-only done");

    // Back-pressure with an ignored request while busy.
    load_word(4'b1111);
    rsp_ready = 1'b0;
    issue(1'b1, 2'd1);
    req_valid = 1'b1; req_mode = 1'b0; req_index = 2'd0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_bit", 32'(rsp_bit), 32'd1);
      chk("bp_hold_index", 32'(rsp_index), 32'd1);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      chk("bp_index", 32'(rsp_index), 32'(i));
      chk("bp_bit", 32'(rsp_bit), 32'd1);
      chk("bp_last", 32'(rsp_last), (i == WIDTH - 1) ? 32'd1 : 32'd0);
      $display("bp idx=%0d bit=%0b", rsp_index, rsp_bit);
      step();
    end
    chk("bp_done_ready", 32'(req_ready), 32'd1);

    // Load coincident with acceptance, then load during the hold.
    load_word(4'b0000);
    rsp_ready = 1'b0;
    load = 1'b1; din = 4'b0001;
    issue(1'b0, 2'd0);
    chk("race_bit", 32'(rsp_bit), 32'd1);
    din = 4'b0000;
    step();
    load = 1'b0;
    chk("race_hold_bit", 32'(rsp_bit), 32'd1);
    chk("race_hold_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    step();
    chk("race_idle", 32'(req_ready), 32'd1);
    $display("load race done");
    single_read(2'd0, 1'b0);

    // Asynchronous abort mid-scan clears the stored word.
    load_word(4'b1111);
    rsp_ready = 1'b1;
    issue(1'b1, 2'd0);
    step();
    rsp_ready = 1'b0;
    chk("abort_pre_index", 32'(rsp_index), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rsp_index", 32'(rsp_index), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    $display("abort done");
    single_read(2'd3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
